tick_sched: RTL



---
 rtl/tick_sched_pkg.sv | 19 +
 rtl/tick_chan.sv | 81 ++++++++
 rtl/tick_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared types and constants for the tick_sched timebase controller.
package tick_sched_pkg;

  localparam int unsigned CNT_W_DEF     = 32;
  localparam int unsigned DEF_DIV_500HZ = 200000;
  localparam int unsigned DEF_DIV_100HZ = 1000000;

  // Encoding presented on state_o
  localparam logic [1:0] STATE_O_IDLE  = 2'd0;
  localparam logic [1:0] STATE_O_RUN   = 2'd1;
  localparam logic [1:0] STATE_O_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_O_IDLE,
    ST_RUN   = STATE_O_RUN,
    ST_PAUSE = STATE_O_PAUSE
  } state_t;

endpackage

// File: rtl/tick_chan.sv
// tick_chan: one tick channel -- period counter, active/shadow divisor, tick and phase.
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_100HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,        // hold counter and phase at zero
  input  logic             i_run,        // advance the counter this edge
  input  logic             i_flush,      // leaving RUN/PAUSE: apply any pending divisor
  input  logic             i_cfg_we,     // config transfer addressed to this channel
  input  logic             i_cfg_direct, // transfer loads div immediately (IDLE)
  input  logic [CNT_W-1:0] i_cfg_div,    // already clamped to >= 1
  output logic             o_pending,
  output logic             o_tick,
  output logic             o_phase
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_tick;
  logic             r_phase;

  logic             w_last;
  logic             w_rise;
  logic             w_wrap;

  // Rise point leaves the extra cycle of an odd period in the low half
  assign w_last = (r_cnt == r_div - CNT_W'(1));
  assign w_rise = (r_cnt == r_div - (r_div >> 1) - CNT_W'(1));
  assign w_wrap = i_run && w_last;

  // Counter, tick and phase; divisor update from config or pending shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_div     <= CNT_W'(DEF_DIV);
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_phase   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_clr) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (i_run) begin
        if (w_last) begin
          r_cnt   <= '0;
          r_tick  <= 1'b1;
          r_phase <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_rise) r_phase <= 1'b1;
        end
      end

      if (i_cfg_we) begin
        if (i_cfg_direct || i_flush) begin
          r_div     <= i_cfg_div;
          r_pending <= 1'b0;
        end else begin
          r_shadow  <= i_cfg_div;
          r_pending <= 1'b1;
        end
      end else if (r_pending && (w_wrap || i_flush)) begin
        r_div     <= r_shadow;
        r_pending <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_tick    = r_tick;
  assign o_phase   = r_phase;

endmodule

// File: rtl/tick_sched.sv
// tick_sched: multi-channel tick/phase timebase with IDLE/RUN/PAUSE sequencing.
// Optional macro TICK_SCHED_CFG_ERR_EN adds the cfg_err pulse output.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEF_DIV0 = DEF_DIV_500HZ,
  parameter int unsigned DEF_DIV1 = DEF_DIV_100HZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] phase,
`ifdef TICK_SCHED_CFG_ERR_EN
  output logic              cfg_err,
`endif
  output logic [1:0]        state_o
);

  state_t            r_state;
  logic [NUM_CH-1:0] w_pending;
  logic [7:0]        w_pend_pad;
  logic              w_xfer;
  logic              w_clr;
  logic              w_run;
  logic              w_flush;
  logic              w_direct;
  logic [CNT_W-1:0]  w_div_in;

  // Ready reflects the addressed channel; out-of-range channels are always ready
  assign w_pend_pad = 8'(w_pending);
  assign cfg_ready  = !w_pend_pad[cfg_ch];
  assign w_xfer     = cfg_valid && cfg_ready;
  assign w_div_in   = (cfg_div == '0) ? CNT_W'(1) : cfg_div;

  // stop wins this edge, so counters are already zero on the first IDLE cycle
  assign w_clr    = (r_state == ST_IDLE) || stop;
  assign w_run    = (r_state == ST_RUN) && !stop;
  assign w_flush  = stop && (r_state != ST_IDLE);
  assign w_direct = (r_state == ST_IDLE);

  // Sequencer: stop > start > pause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (!stop && start) r_state <= ST_RUN;
        ST_RUN:   if (stop) r_state <= ST_IDLE;
                  else if (pause) r_state <= ST_PAUSE;
        ST_PAUSE: if (stop) r_state <= ST_IDLE;
                  else if (!pause) r_state <= ST_RUN;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign state_o = r_state;

`ifdef TICK_SCHED_CFG_ERR_EN
  logic r_cfg_err;
  logic w_ch_bad;

  assign w_ch_bad = (32'(cfg_ch) >= NUM_CH);

  // One-cycle flag after a clamped or discarded transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cfg_err <= 1'b0;
    else     r_cfg_err <= w_xfer && ((cfg_div == '0) || w_ch_bad);
  end

  assign cfg_err = r_cfg_err;
`endif

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    tick_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV ((g == 0) ? DEF_DIV0 : DEF_DIV1)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (w_clr),
      .i_run        (w_run),
      .i_flush      (w_flush),
      .i_cfg_we     (w_xfer && (cfg_ch == 3'(g))),
      .i_cfg_direct (w_direct),
      .i_cfg_div    (w_div_in),
      .o_pending    (w_pending[g]),
      .o_tick       (tick[g]),
      .o_phase      (phase[g])
    );
  end

endmodule
